// File: rtl/fc_logits_mac_if.sv
// Feature stream, weight ROM port, bias/logit buses and status for fc_logits_mac.
// The slave modport is the MAC block; master is the surrounding datapath.
interface fc_logits_mac_if #(
  parameter int NUM_IN      = 64,
  parameter int NUM_CLASSES = 10,
  parameter int IN_W        = 8,
  parameter int W_W         = 8,
  parameter int ACC_W       = 32
);
  localparam int AW = $clog2(NUM_IN);

  logic                         start;
  logic                         in_valid;
  logic                         in_ready;
  logic [IN_W-1:0]              in_data;
  logic                         w_rd_en;
  logic [AW-1:0]                w_addr;
  logic [NUM_CLASSES*W_W-1:0]   w_row;
  logic [NUM_CLASSES*ACC_W-1:0] bias_in;
  logic [NUM_CLASSES*ACC_W-1:0] logits;
  logic                         busy;
  logic                         done;

  modport slave (
    input  start, in_valid, in_data, w_row, bias_in,
    output in_ready, w_rd_en, w_addr, logits, busy, done
  );

  modport master (
    output start, in_valid, in_data, w_row, bias_in,
    input  in_ready, w_rd_en, w_addr, logits, busy, done
  );
endinterface

// File: rtl/fc_logits_mac.sv
// Final fully-connected layer: streams NUM_IN features against ROM weight rows and
// accumulates NUM_CLASSES bias-seeded logits for the argmax stage.
//
// state | meaning
// IDLE  | waiting for start, accumulators hold last result (or reset zeros)
// LOAD  | one cycle after bias load, no MAC activity
// RUN   | accepting features; MAC trails each accepted beat by one cycle
// DONE  | logits final and held, done high until next start
module fc_logits_mac #(
  parameter int NUM_IN      = 64,
  parameter int NUM_CLASSES = 10,
  parameter int IN_W        = 8,
  parameter int W_W         = 8,
  parameter int ACC_W       = 32
) (
  input  logic                clk,
  input  logic                reset,
  fc_logits_mac_if.slave      bus
);
  localparam int AW = $clog2(NUM_IN);
  localparam int CW = $clog2(NUM_IN + 1);
  localparam int PW = IN_W + W_W;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_e;

  state_e                       state_q, state_d;
  logic [CW-1:0]                count_q, count_d;
  logic [NUM_CLASSES*ACC_W-1:0] acc_q, acc_d;
  logic [IN_W-1:0]              f_q, f_d;
  logic                         mac_pend_q, mac_pend_d;
  logic                         in_ready;
  logic                         w_rd_en;

  // Both operands widened to the full product width so the low PW bits are exact.
  function automatic logic [ACC_W-1:0] mac_term(input logic [IN_W-1:0] f,
                                                input logic [W_W-1:0]  w);
    logic [PW-1:0] p;
    p = {{W_W{f[IN_W-1]}}, f} * {{IN_W{w[W_W-1]}}, w};
    return {{(ACC_W-PW){p[PW-1]}}, p};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      acc_q      <= '0;
      f_q        <= '0;
      mac_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      f_q        <= f_d;
      mac_pend_q <= mac_pend_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    acc_d      = acc_q;
    f_d        = f_q;
    mac_pend_d = 1'b0;
    in_ready   = 1'b0;
    w_rd_en    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          acc_d   = bus.bias_in;
          count_d = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: state_d = S_RUN;
      S_RUN: begin
        in_ready = (count_q < CW'(NUM_IN));
        if (bus.in_valid && in_ready) begin
          w_rd_en    = 1'b1;
          f_d        = bus.in_data;
          mac_pend_d = 1'b1;
          count_d    = count_q + CW'(1);
        end
        // w_row now holds the row read for the beat registered in f_q.
        if (mac_pend_q) begin
          for (int k = 0; k < NUM_CLASSES; k++) begin
            acc_d[k*ACC_W +: ACC_W] = acc_q[k*ACC_W +: ACC_W]
                                      + mac_term(f_q, bus.w_row[k*W_W +: W_W]);
          end
        end
        if (count_q == CW'(NUM_IN) && !mac_pend_q) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready = in_ready;
  assign bus.w_rd_en  = w_rd_en;
  assign bus.w_addr   = count_q[AW-1:0];
  assign bus.logits   = acc_q;
  assign bus.busy     = (state_q == S_LOAD) || (state_q == S_RUN);
  assign bus.done     = (state_q == S_DONE);
endmodule

// File: tb/tb_fc_logits_mac.sv
// Directed bench for fc_logits_mac: behavioural weight ROM, hand-computed logits,
// latency, address sequence, stray start/data and reset-mid-run checks.
module tb_fc_logits_mac;
  localparam int NI = 64;
  localparam int NC = 10;
  localparam int IW = 8;
  localparam int WW = 8;
  localparam int AC = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fc_logits_mac_if #(.NUM_IN(NI), .NUM_CLASSES(NC), .IN_W(IW), .W_W(WW), .ACC_W(AC)) bus();

  fc_logits_mac #(.NUM_IN(NI), .NUM_CLASSES(NC), .IN_W(IW), .W_W(WW), .ACC_W(AC)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int feat[NI];
  int wt[NI][NC];
  int bias[NC];
  int expv[NC];
  int addr_log[$];
  int n_checks = 0;
  int n_pass = 0;

  // Synchronous weight ROM: row appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.w_rd_en) begin
      for (int k = 0; k < NC; k++) bus.w_row[k*WW +: WW] <= WW'(wt[bus.w_addr][k]);
      addr_log.push_back(int'(bus.w_addr));
    end
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic longint logit(input int k);
    logic [AC-1:0] v;
    v = bus.logits[k*AC +: AC];
    return longint'($signed(v));
  endfunction

  function automatic void golden();
    for (int k = 0; k < NC; k++) begin
      expv[k] = bias[k];
      for (int i = 0; i < NI; i++) expv[k] += feat[i] * wt[i][k];
    end
  endfunction

  task automatic pulse_start();
    for (int k = 0; k < NC; k++) bus.bias_in[k*AC +: AC] = bias[k];
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("start_done_low", bus.done, 0);
    check("start_busy", bus.busy, 1);
  endtask

  task automatic feed(input int gap, input int stop_at, input bit stray);
    int  idx = 0;
    int  cyc = 0;
    bit  x;
    while (idx < stop_at && cyc < 3000) begin
      bus.in_valid = (gap == 0) ? 1'b1 : ($urandom_range(99) >= gap);
      bus.in_data  = IW'(feat[idx]);
      bus.start    = stray && (idx == 10);
      x = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      cyc++;
      if (x) idx++;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    check("feed_beats", idx, stop_at);
  endtask

  task automatic run_inf(input string tag, input int gap, input bit stray);
    int lat = 0;
    int bad = 0;
    addr_log.delete();
    pulse_start();
    feed(gap, NI, stray);
    while (!bus.done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, 2);
    check({tag, "_nreads"}, addr_log.size(), NI);
    for (int i = 0; i < addr_log.size(); i++) if (addr_log[i] != i) bad++;
    check({tag, "_addr_seq"}, bad, 0);
    for (int k = 0; k < NC; k++) check($sformatf("%s_logit%0d", tag, k), logit(k), expv[k]);
  endtask

  task automatic set_unit();
    for (int i = 0; i < NI; i++) begin
      feat[i] = i + 1;
      for (int k = 0; k < NC; k++) wt[i][k] = 1;
    end
    for (int k = 0; k < NC; k++) begin
      bias[k] = 0;
      expv[k] = 2080;
    end
  endtask

  initial begin
    int am;
    int nrd;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.bias_in = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_done", bus.done, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_w_rd_en", bus.w_rd_en, 0);
    check("rst_logits_zero", (bus.logits == '0), 1);

    // Zero features: logits equal bias regardless of weights.
    for (int i = 0; i < NI; i++) begin
      feat[i] = 0;
      for (int k = 0; k < NC; k++) wt[i][k] = $urandom_range(255) - 128;
    end
    for (int k = 0; k < NC; k++) begin
      bias[k] = k * 100 - 300;
      expv[k] = k * 100 - 300;
    end
    run_inf("bias", 0, 0);

    set_unit();
    run_inf("unit", 0, 0);

    for (int i = 0; i < NI; i++) begin
      feat[i] = -128;
      for (int k = 0; k < NC; k++) wt[i][k] = -128;
    end
    for (int k = 0; k < NC; k++) begin
      bias[k] = 0;
      expv[k] = 1048576;
    end
    run_inf("neg", 0, 0);

    // Random data with 50% valid gaps and a stray start mid-run.
    for (int i = 0; i < NI; i++) begin
      feat[i] = $urandom_range(255) - 128;
      for (int k = 0; k < NC; k++) wt[i][k] = $urandom_range(255) - 128;
    end
    for (int k = 0; k < NC; k++) bias[k] = $urandom_range(20000) - 10000;
    golden();
    run_inf("gaps", 50, 1);

    // Stray data in DONE must not be consumed.
    nrd = addr_log.size();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h7f;
    repeat (4) begin
      check("done_in_ready", bus.in_ready, 0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check("done_held", bus.done, 1);
    check("done_no_reads", addr_log.size(), nrd);
    for (int k = 0; k < NC; k++) check($sformatf("done_stable%0d", k), logit(k), expv[k]);

    // Reset after 20 beats discards the partial sums.
    set_unit();
    pulse_start();
    feed(0, 20, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_done", bus.done, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    check("midrst_w_rd_en", bus.w_rd_en, 0);
    check("midrst_logits_zero", (bus.logits == '0), 1);
    run_inf("after_rst", 0, 0);

    // Class 7 wins; then start again straight from DONE with different data.
    for (int i = 0; i < NI; i++) begin
      feat[i] = (i % 5) + 1;
      for (int k = 0; k < NC; k++) wt[i][k] = (k == 7) ? 3 : ((i + k) % 3) - 1;
    end
    for (int k = 0; k < NC; k++) bias[k] = 5;
    golden();
    run_inf("cls7", 0, 0);
    am = 0;
    for (int k = 1; k < NC; k++) if (logit(k) > logit(am)) am = k;
    check("argmax", am, 7);
    set_unit();
    run_inf("b2b", 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fc_logits_mac.md
Name: fc_logits_mac

Overview:
- Final fully-connected layer of the CNN accelerator; sits directly upstream of the argmax stage.
- Consumes a serial stream of NUM_IN signed feature values and multiplies each against one weight row from an external synchronous ROM.
- Accumulates NUM_CLASSES signed logits, starting from bias, and presents them on a packed bus with a held done flag.
- Argmax reads the logits once done is high.

Parameters:
- NUM_IN, 64, number of input features per inference.
- NUM_CLASSES, 10, number of output logits.
- IN_W, 8, signed feature width.
- W_W, 8, signed weight width.
- ACC_W, 32, signed accumulator / logit width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin an inference; sampled in IDLE and DONE only.
- in_valid  in  1  feature beat valid.
- in_ready  out  1  block can accept a feature this cycle.
- in_data  in  IN_W  signed feature value.
- w_rd_en  out  1  weight ROM read strobe.
- w_addr  out  clog2(NUM_IN)  weight row index, equal to the feature index.
- w_row  in  NUM_CLASSES*W_W  weight row, valid the cycle after w_rd_en; class k is at bits [k*W_W +: W_W].
- bias_in  in  NUM_CLASSES*ACC_W  signed biases, same packing; sampled on start.
- logits  out  NUM_CLASSES*ACC_W  signed accumulators, same packing.
- busy  out  1  high in LOAD and RUN.
- done  out  1  high in DONE.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, count=0, all accumulators=0.
  - logits=0, in_ready=0, w_rd_en=0, busy=0, done=0.
  - Reset wins over every other event, including mid-run; partial sums are discarded and w_rd_en drops the next cycle.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - start=1 → each accumulator k loads bias_in[k], count=0, done=0, next state LOAD.
- LOAD: single cycle, no MAC activity, next state RUN.
- RUN, accept rule:
  - in_ready = (count < NUM_IN).
  - A beat transfers when in_valid && in_ready.
  - On a transfer: w_rd_en=1, w_addr=count, feature registered into f_reg, mac_pend=1, count increments.
- RUN, MAC rule:
  - The cycle after a transfer, for all k: acc[k] += sext(f_reg) * sext(w_row[k]).
  - Product width is IN_W+W_W; it is sign-extended to ACC_W.
  - Accumulation wraps two's complement, no saturation. Defaults cannot overflow: 64 × 2^14 < 2^31.
- Throughput: one feature per cycle. Back-to-back transfers overlap the ROM read of beat n+1 with the MAC of beat n.
- Bubbles: in_valid low stalls indefinitely. No timeout; accumulators hold.
- RUN → DONE when count==NUM_IN and mac_pend==0, i.e. the cycle after the last MAC.
  - Latency from last beat accepted to done=1 is 2 cycles.
- DONE:
  - done=1 is held and logits are stable until the next start or reset.
  - start in DONE behaves exactly as start in IDLE: done falls the next cycle and accumulators reload bias.
- start asserted in LOAD or RUN is ignored.
- in_valid outside RUN is ignored; in_ready=0 there and no data is consumed.
- logits is driven directly from the accumulators. It is valid only while done=1 and changes during RUN.

Test Plan:
- Reset mid-run: reset asserted after 20 beats → the next cycle has done=0, busy=0, logits all 0, in_ready=0. A new start then completes normally with correct values.
- Bias only, zero features: all features=0, bias k = k*100-300 → done after 64 beats + 2 cycles; logits[k] = k*100-300 exactly.
- Unit weights: every weight=1, features 1..64, bias 0 → every logit = 2080. Also checks negative extremes: all features -128, all weights -128, bias 0 → every logit = 1048576.
- Backpressure and gaps: in_valid toggled randomly at 50% → exactly 64 transfers, w_addr sequence 0..63 with no repeats or skips. Logits match the golden model computed with no gaps.
- Stray starts and stray data: start pulsed during RUN → ignored and result unchanged. in_valid=1 in DONE → in_ready=0 and nothing consumed.
- Back-to-back inferences: start in DONE the same cycle argmax samples → done drops one cycle later, the second result is independent of the first, and class 7 scoring highest gives argmax output 7.
